// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, fetch queue entry, word alignment.
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & {{(PC_W-2){1'b1}}, 2'b00};
    endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_pop  = pop_i && (r_count != '0);
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) r_mem[r_wr_ptr] <= push_data_i;
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: owns the fetch PC, keeps one memory read outstanding,
// queues returned words with their PCs and hands them to the CPU; redirect flushes.
module instr_prefetch_buf
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   mem_req_o,
    output logic [PC_W-1:0]        mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [INSTR_W-1:0]     mem_data_i,
    output logic                   instr_valid_o,
    output logic [INSTR_W-1:0]     instr_o,
    output logic [PC_W-1:0]        instr_pc_o,
    input  logic                   instr_ready_i,
    input  logic                   redirect_i,
    input  logic [PC_W-1:0]        redirect_pc_i,
    output fetch_state_t           dbg_state_o,
    output logic [$clog2(DEPTH):0] dbg_count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LVL = (CW+1)'(DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] w_fetch_pc_nxt;
    logic [PC_W-1:0] r_addr;
    logic [PC_W-1:0] w_addr_nxt;
    logic [PC_W-1:0] w_redirect_pc;
    logic [PC_W-1:0] w_fetch_inc;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_level;
    logic            w_space;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Handshakes: memory word transfers on mem_ack_i while mem_req_o is high (addr held
    // stable until then); CPU takes the head when instr_valid_o & instr_ready_i, unless
    // redirect_i is high in that cycle.
    assign w_redirect_pc = align_pc(redirect_pc_i);
    assign w_fetch_inc   = r_fetch_pc + PC_W'(4);
    assign w_pop         = !w_empty && instr_ready_i && !redirect_i;
    assign w_push        = (r_state == WAIT) && mem_ack_i && !redirect_i;
    assign w_push_entry  = '{pc: r_fetch_pc, instr: mem_data_i};

    // Occupancy after this cycle's push/pop; a new request needs a free slot in it.
    assign w_level = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
    assign w_space = (w_level < DEPTH_LVL);

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (redirect_i),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    // In DROP the bus still carries the stale address while fetch_pc already holds the new one.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        unique case (r_state)
            IDLE: begin
                if (redirect_i) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_addr_nxt     = w_redirect_pc;
                    w_state_nxt    = WAIT;
                end else if (w_space) begin
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    if (mem_ack_i) begin
                        w_addr_nxt  = w_redirect_pc;
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end else if (mem_ack_i) begin
                    w_fetch_pc_nxt = w_fetch_inc;
                    if (w_space) begin
                        w_addr_nxt  = w_fetch_inc;
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_i) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    if (mem_ack_i) begin
                        w_addr_nxt  = w_redirect_pc;
                        w_state_nxt = WAIT;
                    end
                end else if (mem_ack_i) begin
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_req_o     = (r_state != IDLE);
    assign mem_addr_o    = r_addr;
    assign instr_valid_o = !w_empty;
    assign instr_o       = w_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc_o    = w_empty ? '0 : w_head.pc;
    assign dbg_state_o   = r_state;
    assign dbg_count_o   = w_count;
endmodule

// File: doc/instr_prefetch_buf.md
# instr_prefetch_buf

Instruction prefetch buffer between the instruction memory and the single-cycle CPU datapath. It owns the fetch PC, issues word reads to an instruction memory with variable latency over a req/ack handshake, and queues returned instructions with their PCs in a small FIFO. The CPU consumes them over a valid/ready handshake and redirects fetch on taken branches (PCSrc = Branch & Zero).

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, synchronous, active-low
- mem_req_o  output  1  read request to instruction memory
- mem_addr_o  output  32  byte address of requested word
- mem_ack_i  input  1  memory has returned mem_data_i this cycle
- mem_data_i  input  32  instruction word, valid when mem_ack_i=1
- instr_valid_o  output  1  FIFO head holds an instruction
- instr_o  output  32  instruction at FIFO head
- instr_pc_o  output  32  PC of instruction at FIFO head
- instr_ready_i  input  1  CPU consumes head this cycle when instr_valid_o=1
- redirect_i  input  1  flush and restart fetch (taken branch)
- redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored, forced to 0

## Operation
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, result kept), DROP (request outstanding, result to be discarded).
- IDLE -> WAIT when count + 0 < DEPTH and no redirect: assert mem_req_o with mem_addr_o = fetch_pc.
- WAIT: mem_req_o and mem_addr_o held stable until mem_ack_i. On ack: push {fetch_pc, mem_data_i}, fetch_pc += 4 (wraps mod 2^32), -> WAIT again if space remains after this push, else IDLE.
- Issue rule: a new request starts only if count + (push this cycle) − (pop this cycle) < DEPTH, so an ack never meets a full FIFO.
- DROP: request held until mem_ack_i; data discarded, no push; -> WAIT at fetch_pc.
- Redirect (highest priority): FIFO flushed (count=0), fetch_pc = {redirect_pc_i[31:2],2'b00}. From IDLE -> WAIT at new PC next cycle; from WAIT without same-cycle ack -> DROP; from WAIT with same-cycle ack -> ack dropped, -> WAIT at new PC; in DROP -> stays DROP (or WAIT if ack same cycle), fetch_pc updated.
- Pop when instr_valid_o & instr_ready_i & !redirect_i. Simultaneous pop and push allowed at any count, including full.
- instr_o/instr_pc_o = head entry when valid, 32'h0 when empty.
- Reset mid-transaction: FSM to IDLE, outstanding request abandoned; memory must tolerate request drop on reset.

## Timing
- Reset values: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, count=0, state IDLE.
- First cycle after rst_i deasserts: mem_req_o=1, mem_addr_o=RESET_PC.
- Ack at edge N: entry visible (instr_valid_o=1) in cycle after N; back-to-back request at fetch_pc+4 asserted from that same cycle (one idle-free issue per ack, one outstanding max).
- Redirect at edge N: instr_valid_o=0 from cycle after N; new-PC request no earlier than cycle after N (IDLE case) or cycle after stale ack (DROP case).
- All outputs registered; no combinational path from any input to any output.

## Structure
- Shared package cpu_pkg: INSTR_W=32, PC_W=32, fetch FSM state enum {IDLE, WAIT, DROP}, NOP instruction constant 32'h0.
- One sub-module: prefetch_fifo, synchronous FIFO of width 64 ({pc,instr}), parameter DEPTH, ports push/pop/flush/full/empty/count; count width $clog2(DEPTH)+1.
- Top holds FSM, fetch_pc register, issue-space logic.

## Test plan
- Reset, memory acks 1 cycle after every req, ready=1 -> instructions at PCs 0x0,0x4,0x8,... delivered in order, mem_addr_o never changes while req high without ack.
- ready=0, DEPTH=4 -> exactly 4 acks accepted, mem_req_o drops to 0, count=4; raise ready -> fetch resumes at 0x10.
- Memory latency 5 cycles, redirect_i with redirect_pc_i=0x0000_0103 mid-WAIT -> stale ack dropped, next request at 0x0000_0100, first delivered instr_pc_o=0x100.
- Redirect in same cycle as ack and pop on full FIFO -> FIFO empty next cycle, no stale entry ever valid, next request at redirect PC.
- RESET_PC=32'hFFFF_FFF8 -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- rst_i asserted while WAIT with count=2 -> all outputs at reset values next cycle; restart fetch at RESET_PC.
